adc_capture_array: RTL and testbench
====================================

# adc_capture_array

Parametrised successor to the fixed six-channel, 8-bit ADC front end. It drives one shared serial clock and chip select for NUM_CH serial ADCs and deserialises all channels in lock-step. Each conversion is published as one packed frame through a valid/ready handshake, with overrun detection and a frame counter. It sits between the load-circuit ADC pins and the data-store/Nios capture path, and supports single-shot and continuous modes.

## Interface
- NUM_CH, 6: number of ADC data lines sharing SCLK/CS (1..16)
- DATA_WIDTH, 8: result bits per channel, MSB first (4..16)
- LEAD_BITS, 1: SCLK periods after CS falls whose data is discarded (0..4)
- CLK_DIV, 2: clk cycles per SCLK half-period (>=1)
- QUIET, 4: clk cycles CS stays high between conversions (>=1)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  continuous mode; a new conversion starts whenever the block is idle
- start  in  1  single-shot request pulse, honoured only in IDLE when enable=0
- data_in  in  NUM_CH  serial ADC data, bit i = channel i
- adc_sclk  out  1  serial clock to all ADCs, idles low
- adc_cs_n  out  1  shared chip select, active low
- frame_data  out  NUM_CH*DATA_WIDTH  channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- frame_valid  out  1  frame available
- frame_ready  in  1  consumer accepts the frame when valid&&ready
- overrun  out  1  sticky; set when an unaccepted frame is overwritten; cleared only by reset
- frame_count  out  16  frames completed, wraps at 0xFFFF->0
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, CONVERT, QUIET.
- IDLE -> CONVERT when enable=1, or when enable=0 and start=1. adc_cs_n falls on the transition cycle.
- CONVERT: the divider toggles adc_sclk every CLK_DIV clk cycles, starting low. The block runs exactly LEAD_BITS+DATA_WIDTH SCLK periods.
- On each SCLK rising edge, data_in is shifted into the per-channel shift registers. The first LEAD_BITS captures are discarded and the remaining DATA_WIDTH captures are kept, MSB first.
- CONVERT -> QUIET after the final falling edge of adc_sclk. On that cycle adc_cs_n rises, the shift registers are copied to frame_data, frame_valid is set, and frame_count increments.
- QUIET lasts exactly QUIET clk cycles, then returns to IDLE.
- Handshake: frame_valid stays high until a cycle with frame_ready=1, then clears on the next cycle. frame_data is stable while frame_valid is high.
- New frame completes while frame_valid=1 and frame_ready=0: frame_data is overwritten, frame_valid stays 1, overrun is set.
- Acceptance on the same cycle a new frame completes: the new frame loads, frame_valid stays 1, no overrun.
- Dropping enable mid-conversion does not abort. The current frame completes, then the block idles.
- start pulses during CONVERT or QUIET are ignored, not queued.

## Timing
- Reset values: adc_sclk=0, adc_cs_n=1, frame_valid=0, frame_data=0, overrun=0, frame_count=0, busy=0, state=IDLE.
- Reset mid-conversion returns all outputs to these values on the next edge. No partial frame is emitted.
- Data sample point: the data_in value present in the clk cycle where adc_sclk is registered 0->1.
- Conversion length: CS low for 2*CLK_DIV*(LEAD_BITS+DATA_WIDTH) clk cycles.
- frame_valid rises in the same cycle adc_cs_n rises.
- Continuous period: 2*CLK_DIV*(LEAD_BITS+DATA_WIDTH) + QUIET + 1 clk cycles. The +1 is the IDLE cycle.
- Width rule: frame_count is free-running modulo 2^16 with no saturation.

## Structure
- Package adc_capture_pkg holds the state enum (IDLE/CONVERT/QUIET), the frame-width localparam function, and the bit-counter width function (clog2 of LEAD_BITS+DATA_WIDTH+1).
- Sub-module adc_sclk_gen: CLK_DIV counter. Outputs adc_sclk plus single-cycle rise/fall strobes, and is held low/reset whenever the FSM is not in CONVERT.
- Per-channel shift registers are built with a generate loop in the top of the block.

## Test plan
- Defaults, single-shot. ADC model returns ch i = 8'h10+i after one lead bit. Pulse start -> CS low for 36 cycles, frame_data = {8'h15,...,8'h10}, frame_valid high, frame_count=1.
- Continuous, frame_ready tied 1 -> one frame every 41 cycles, overrun stays 0, frame_count=10 after 410 cycles.
- Continuous, frame_ready tied 0 -> the second frame overwrites frame_data and overrun=1 at the second CS rise.
- Ready coincident with the next frame completion -> new data is loaded, frame_valid stays 1, overrun=0.
- Reset asserted 20 cycles into CONVERT -> next cycle adc_cs_n=1, adc_sclk=0, frame_valid=0, frame_count unchanged at 0.
- Parameters NUM_CH=3, DATA_WIDTH=12, LEAD_BITS=0, CLK_DIV=1 -> CS low 24 cycles, 12-bit values 12'hABC/12'h123/12'hFFF captured exactly.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared types and sizing helpers for the parametrised ADC capture array.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_QUIET   = 2'd2
  } capState_e;

  // Width of the packed multi-channel frame.
  function automatic int frameWidth(input int numCh, input int dataWidth);
    return numCh * dataWidth;
  endfunction

  // Width needed to count every SCLK period of one conversion, including the end value.
  function automatic int bitCntWidth(input int leadBits, input int dataWidth);
    return $clog2(leadBits + dataWidth + 1);
  endfunction

  // Width of a counter that runs 0..maxCount-1, never narrower than one bit.
  function automatic int cntWidth(input int maxCount);
    return (maxCount > 1) ? $clog2(maxCount) : 1;
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial clock divider: toggles SCLK every CLK_DIV clk cycles while running,
// and flags the cycle just before each registered rising/falling edge.
module adc_sclk_gen
  import adc_capture_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = cntWidth(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] divCnt_q;
  logic             sclk_q;
  logic             halfDone;

  assign halfDone = run_i && (divCnt_q == LAST_CNT);
  assign rise_o   = halfDone && !sclk_q;
  assign fall_o   = halfDone && sclk_q;
  assign sclk_o   = sclk_q;

  // Divider counter and SCLK register; parked low with a cleared count whenever not running.
  always_ff @(posedge clk) begin
    if (reset || !run_i) begin
      divCnt_q <= '0;
      sclk_q   <= 1'b0;
    end else if (divCnt_q == LAST_CNT) begin
      divCnt_q <= '0;
      sclk_q   <= ~sclk_q;
    end else begin
      divCnt_q <= divCnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/adc_capture_array.sv
// Lock-step deserialiser for NUM_CH serial ADCs sharing one SCLK and CS,
// publishing each conversion as one packed frame over a valid/ready handshake.
module adc_capture_array
  import adc_capture_pkg::*;
#(
  parameter int NUM_CH     = 6,
  parameter int DATA_WIDTH = 8,
  parameter int LEAD_BITS  = 1,
  parameter int CLK_DIV    = 2,
  parameter int QUIET      = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             start,
  input  logic [NUM_CH-1:0]                data_in,
  output logic                             adc_sclk,
  output logic                             adc_cs_n,
  output logic [NUM_CH*DATA_WIDTH-1:0]     frame_data,
  output logic                             frame_valid,
  input  logic                             frame_ready,
  output logic                             overrun,
  output logic [15:0]                      frame_count,
  output logic                             busy
);

  localparam int FRAME_W     = frameWidth(NUM_CH, DATA_WIDTH);
  localparam int TOTAL_BITS  = LEAD_BITS + DATA_WIDTH;
  localparam int BIT_CNT_W   = bitCntWidth(LEAD_BITS, DATA_WIDTH);
  localparam int QUIET_CNT_W = cntWidth(QUIET);
  localparam logic [BIT_CNT_W-1:0]   LAST_BIT   = BIT_CNT_W'(TOTAL_BITS);
  localparam logic [QUIET_CNT_W-1:0] LAST_QUIET = QUIET_CNT_W'(QUIET - 1);

  capState_e              state_q;
  logic                   csN_q;
  logic                   busy_q;
  logic [BIT_CNT_W-1:0]   bitCnt_q;
  logic [QUIET_CNT_W-1:0] quietCnt_q;
  logic [FRAME_W-1:0]     frameData_q;
  logic                   frameValid_q;
  logic                   overrun_q;
  logic [15:0]            frameCount_q;

  logic               sclkRise;
  logic               sclkFall;
  logic               frameDone;
  logic [FRAME_W-1:0] frameShift;

  adc_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) uSclkGen (
    .clk   (clk),
    .reset (reset),
    .run_i (state_q == ST_CONVERT),
    .sclk_o(adc_sclk),
    .rise_o(sclkRise),
    .fall_o(sclkFall)
  );

  // The last falling SCLK edge of a conversion is the one that follows the final rising edge.
  assign frameDone = (state_q == ST_CONVERT) && sclkFall && (bitCnt_q == LAST_BIT);

  // Every rising edge shifts MSB-first into each channel; the lead bits simply fall off
  // the top, so after TOTAL_BITS shifts only the last DATA_WIDTH captures remain.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : gChannel
    logic [DATA_WIDTH-1:0] shift_q;

    // Per-channel deserialiser.
    always_ff @(posedge clk) begin
      if (reset) begin
        shift_q <= '0;
      end else if (sclkRise) begin
        shift_q <= {shift_q[DATA_WIDTH-2:0], data_in[ch]};
      end
    end

    assign frameShift[ch*DATA_WIDTH +: DATA_WIDTH] = shift_q;
  end

  // Conversion sequencer: owns state, chip select, busy and the bit/quiet counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      csN_q      <= 1'b1;
      busy_q     <= 1'b0;
      bitCnt_q   <= '0;
      quietCnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable || start) begin
            state_q  <= ST_CONVERT;
            csN_q    <= 1'b0;
            busy_q   <= 1'b1;
            bitCnt_q <= '0;
          end
        end
        ST_CONVERT: begin
          if (sclkRise) begin
            bitCnt_q <= bitCnt_q + 1'b1;
          end
          if (frameDone) begin
            state_q    <= ST_QUIET;
            csN_q      <= 1'b1;
            quietCnt_q <= '0;
          end
        end
        ST_QUIET: begin
          if (quietCnt_q == LAST_QUIET) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            quietCnt_q <= quietCnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          csN_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output frame register with valid/ready handshake, sticky overrun and frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      frameData_q  <= '0;
      frameValid_q <= 1'b0;
      overrun_q    <= 1'b0;
      frameCount_q <= '0;
    end else if (frameDone) begin
      frameData_q  <= frameShift;
      frameValid_q <= 1'b1;
      frameCount_q <= frameCount_q + 16'd1;
      if (frameValid_q && !frame_ready) begin
        overrun_q <= 1'b1;
      end
    end else if (frameValid_q && frame_ready) begin
      frameValid_q <= 1'b0;
    end
  end

  assign adc_cs_n    = csN_q;
  assign busy        = busy_q;
  assign frame_data  = frameData_q;
  assign frame_valid = frameValid_q;
  assign overrun     = overrun_q;
  assign frame_count = frameCount_q;

endmodule

// File: tb/tb_adc_capture_array.sv
// Self-checking bench for adc_capture_array: a default six-channel instance driven
// from a vector table plus hand-written sequences, and a 3x12-bit fast-SCLK instance.
module tb_adc_capture_array;

  localparam int A_CH    = 6;
  localparam int A_W     = 8;
  localparam int A_LEAD  = 1;
  localparam int A_DIV   = 2;
  localparam int A_QUIET = 4;
  localparam int A_CONV  = 2 * A_DIV * (A_LEAD + A_W);

  localparam int B_CH    = 3;
  localparam int B_W     = 12;
  localparam int B_LEAD  = 0;
  localparam int B_DIV   = 1;
  localparam int B_QUIET = 4;
  localparam int B_CONV  = 2 * B_DIV * (B_LEAD + B_W);

  typedef struct {
    logic [47:0] words;
    logic        leadLevel;
    logic [47:0] expFrame;
    logic [15:0] expCount;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  logic                  enableA, startA, readyA;
  logic [A_CH-1:0]       dataA;
  logic                  sclkA, csNA, validA, overrunA, busyA;
  logic [A_CH*A_W-1:0]   frameA;
  logic [15:0]           countA;

  logic                  enableB, startB, readyB;
  logic [B_CH-1:0]       dataB;
  logic                  sclkB, csNB, validB, overrunB, busyB;
  logic [B_CH*B_W-1:0]   frameB;
  logic [15:0]           countB;

  logic [47:0] adcWordsA;
  logic        leadLevelA;
  logic [35:0] adcWordsB;
  int          fallCntA = 0;
  int          fallCntB = 0;
  logic        prevSclkA = 1'b0;
  logic        prevSclkB = 1'b0;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[4];

  always #5 clk = ~clk;

  adc_capture_array #(
    .NUM_CH(A_CH), .DATA_WIDTH(A_W), .LEAD_BITS(A_LEAD), .CLK_DIV(A_DIV), .QUIET(A_QUIET)
  ) dutA (
    .clk(clk), .reset(reset), .enable(enableA), .start(startA), .data_in(dataA),
    .adc_sclk(sclkA), .adc_cs_n(csNA), .frame_data(frameA), .frame_valid(validA),
    .frame_ready(readyA), .overrun(overrunA), .frame_count(countA), .busy(busyA)
  );

  adc_capture_array #(
    .NUM_CH(B_CH), .DATA_WIDTH(B_W), .LEAD_BITS(B_LEAD), .CLK_DIV(B_DIV), .QUIET(B_QUIET)
  ) dutB (
    .clk(clk), .reset(reset), .enable(enableB), .start(startB), .data_in(dataB),
    .adc_sclk(sclkB), .adc_cs_n(csNB), .frame_data(frameB), .frame_valid(validB),
    .frame_ready(readyB), .overrun(overrunB), .frame_count(countB), .busy(busyB)
  );

  // ADC bit presented after k SCLK falling edges: lead level first, then the word MSB first.
  function automatic logic adcBit(input logic [15:0] word, input int width, input int lead,
                                  input logic leadLevel, input int k);
    logic [15:0] w;
    w = word;
    if (k < lead) return leadLevel;
    if (k >= lead + width) return 1'b0;
    return w[width - 1 - (k - lead)];
  endfunction

  // ADC models change their output only after an SCLK falling edge, like a real SPI ADC.
  always @(negedge clk) begin
    if (csNA) fallCntA = 0;
    else if (prevSclkA && !sclkA) fallCntA = fallCntA + 1;
    prevSclkA = sclkA;
    if (csNB) fallCntB = 0;
    else if (prevSclkB && !sclkB) fallCntB = fallCntB + 1;
    prevSclkB = sclkB;
  end

  always_comb begin
    dataA = '0;
    for (int ch = 0; ch < A_CH; ch++)
      dataA[ch] = adcBit(16'(adcWordsA[ch*A_W +: A_W]), A_W, A_LEAD, leadLevelA, fallCntA);
  end

  always_comb begin
    dataB = '0;
    for (int ch = 0; ch < B_CH; ch++)
      dataB[ch] = adcBit(16'(adcWordsB[ch*B_W +: B_W]), B_W, B_LEAD, 1'b0, fallCntB);
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not complete");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    reset   = 1'b1;
    enableA = 1'b0; startA = 1'b0; readyA = 1'b0;
    enableB = 1'b0; startB = 1'b0; readyB = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic waitIdleA(input int budget, input string name);
    int n = 0;
    while (busyA && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 64'(busyA), 64'd0);
  endtask

  // One single-shot conversion on DUT A from a table record, then accept and idle.
  task automatic applyStimulus(input vec_t v, input int idx);
    int n = 0;
    adcWordsA  = v.words;
    leadLevelA = v.leadLevel;
    @(negedge clk) startA = 1'b1;
    @(negedge clk) startA = 1'b0;
    checkOutput($sformatf("v%0d_cs_fall", idx), 64'(csNA), 64'd0);
    while (!csNA && n < 200) begin
      n++;
      @(negedge clk);
    end
    checkOutput($sformatf("v%0d_cs_low_cycles", idx), 64'(n), 64'(A_CONV));
    checkOutput($sformatf("v%0d_valid_at_cs_rise", idx), 64'(validA), 64'd1);
    checkOutput($sformatf("v%0d_frame_data", idx), 64'(frameA), 64'(v.expFrame));
    checkOutput($sformatf("v%0d_frame_count", idx), 64'(countA), 64'(v.expCount));
    readyA = 1'b1;
    startA = 1'b1;
    @(negedge clk);
    readyA = 1'b0;
    startA = 1'b0;
    checkOutput($sformatf("v%0d_valid_cleared", idx), 64'(validA), 64'd0);
    waitIdleA(20, $sformatf("v%0d_idle", idx));
    repeat (3) @(negedge clk);
    checkOutput($sformatf("v%0d_quiet_start_ignored", idx), 64'(csNA), 64'd1);
  endtask

  // One single-shot conversion on DUT B.
  task automatic runB(input logic [35:0] words, input logic [35:0] expFrame,
                      input logic [15:0] expCount, input string name);
    int n = 0;
    adcWordsB = words;
    @(negedge clk) startB = 1'b1;
    @(negedge clk) startB = 1'b0;
    while (!csNB && n < 200) begin
      n++;
      @(negedge clk);
    end
    checkOutput({name, "_cs_low_cycles"}, 64'(n), 64'(B_CONV));
    checkOutput({name, "_valid"}, 64'(validB), 64'd1);
    checkOutput({name, "_frame_data"}, 64'(frameB), 64'(expFrame));
    checkOutput({name, "_frame_count"}, 64'(countB), 64'(expCount));
    readyB = 1'b1;
    @(negedge clk);
    readyB = 1'b0;
    n = 0;
    while (busyB && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_idle"}, 64'(busyB), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    enableA = 1'b0; startA = 1'b0; readyA = 1'b0;
    enableB = 1'b0; startB = 1'b0; readyB = 1'b0;
    adcWordsA = '0; leadLevelA = 1'b0; adcWordsB = '0;

    vecs[0] = '{words: 48'h151413121110, leadLevel: 1'b1, expFrame: 48'h151413121110, expCount: 16'd1};
    vecs[1] = '{words: 48'hFF00AA55C33C, leadLevel: 1'b0, expFrame: 48'hFF00AA55C33C, expCount: 16'd2};
    vecs[2] = '{words: 48'h010204081080, leadLevel: 1'b1, expFrame: 48'h010204081080, expCount: 16'd3};
    vecs[3] = '{words: 48'h000000000000, leadLevel: 1'b1, expFrame: 48'h000000000000, expCount: 16'd4};

    // Reset values.
    doReset();
    checkOutput("rst_cs_n", 64'(csNA), 64'd1);
    checkOutput("rst_sclk", 64'(sclkA), 64'd0);
    checkOutput("rst_valid", 64'(validA), 64'd0);
    checkOutput("rst_data", 64'(frameA), 64'd0);
    checkOutput("rst_overrun", 64'(overrunA), 64'd0);
    checkOutput("rst_count", 64'(countA), 64'd0);
    checkOutput("rst_busy", 64'(busyA), 64'd0);

    // Table-driven single shots.
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i], i);

    // Continuous mode with ready tied high: one frame every 41 cycles.
    doReset();
    adcWordsA = 48'h151413121110; leadLevelA = 1'b1;
    readyA = 1'b1; enableA = 1'b1;
    repeat (405) @(negedge clk);
    checkOutput("cont_count_before_10th", 64'(countA), 64'd9);
    @(negedge clk);
    checkOutput("cont_count_10th", 64'(countA), 64'd10);
    repeat (4) @(negedge clk);
    checkOutput("cont_count_410", 64'(countA), 64'd10);
    checkOutput("cont_overrun", 64'(overrunA), 64'd0);
    repeat (10) @(negedge clk);
    enableA = 1'b0;
    waitIdleA(100, "cont_drop_idle");
    checkOutput("cont_drop_completes", 64'(countA), 64'd11);
    checkOutput("cont_drop_data", 64'(frameA), 64'h151413121110);
    repeat (50) @(negedge clk);
    checkOutput("cont_stays_idle", 64'(busyA), 64'd0);
    checkOutput("cont_no_extra_frame", 64'(countA), 64'd11);

    // Continuous mode with ready low: second frame overwrites and sets overrun.
    doReset();
    adcWordsA = 48'h0123456789AB; leadLevelA = 1'b0;
    enableA = 1'b1;
    repeat (36) @(negedge clk);
    checkOutput("ovr_valid_before_first", 64'(validA), 64'd0);
    @(negedge clk);
    checkOutput("ovr_first_valid", 64'(validA), 64'd1);
    checkOutput("ovr_first_data", 64'(frameA), 64'h0123456789AB);
    adcWordsA = 48'hFEDCBA987654;
    repeat (40) @(negedge clk);
    checkOutput("ovr_data_held", 64'(frameA), 64'h0123456789AB);
    checkOutput("ovr_not_yet", 64'(overrunA), 64'd0);
    @(negedge clk);
    checkOutput("ovr_set", 64'(overrunA), 64'd1);
    checkOutput("ovr_new_data", 64'(frameA), 64'hFEDCBA987654);
    checkOutput("ovr_count", 64'(countA), 64'd2);
    enableA = 1'b0; readyA = 1'b1;
    @(negedge clk);
    readyA = 1'b0;
    waitIdleA(20, "ovr_idle");
    checkOutput("ovr_sticky", 64'(overrunA), 64'd1);

    // Ready coincident with the next frame completion.
    doReset();
    adcWordsA = 48'h0123456789AB; leadLevelA = 1'b1;
    enableA = 1'b1;
    repeat (37) @(negedge clk);
    checkOutput("coin_first_data", 64'(frameA), 64'h0123456789AB);
    adcWordsA = 48'h3C3C0F0FF0F0;
    repeat (40) @(negedge clk);
    readyA = 1'b1;
    @(negedge clk);
    readyA = 1'b0; enableA = 1'b0;
    checkOutput("coin_valid", 64'(validA), 64'd1);
    checkOutput("coin_data", 64'(frameA), 64'h3C3C0F0FF0F0);
    checkOutput("coin_overrun", 64'(overrunA), 64'd0);
    @(negedge clk);
    checkOutput("coin_valid_held", 64'(validA), 64'd1);
    readyA = 1'b1;
    @(negedge clk);
    readyA = 1'b0;
    waitIdleA(20, "coin_idle");

    // Reset partway through a conversion.
    doReset();
    adcWordsA = 48'h151413121110; leadLevelA = 1'b1;
    @(negedge clk) startA = 1'b1;
    @(negedge clk) startA = 1'b0;
    repeat (19) @(negedge clk);
    checkOutput("midrst_in_convert", 64'(csNA), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_cs_n", 64'(csNA), 64'd1);
    checkOutput("midrst_sclk", 64'(sclkA), 64'd0);
    checkOutput("midrst_valid", 64'(validA), 64'd0);
    checkOutput("midrst_count", 64'(countA), 64'd0);
    checkOutput("midrst_busy", 64'(busyA), 64'd0);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    checkOutput("midrst_no_frame", 64'(validA), 64'd0);
    checkOutput("midrst_count_after", 64'(countA), 64'd0);

    // Three 12-bit channels, no lead bit, fastest SCLK.
    doReset();
    runB(36'hFFF123ABC, 36'hFFF123ABC, 16'd1, "b0");
    runB(36'h800001F0F, 36'h800001F0F, 16'd2, "b1");
    checkOutput("b_overrun", 64'(overrunB), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
